// File: rtl/fp16_pkg.sv
// FP16 helpers shared by the operand packer: the identity value, the word type
// and the lane-to-bit-slice mapping used on the packed output bus.
package fp16_pkg;

  localparam int unsigned FP16_W   = 16;
  localparam logic [15:0] FP16_ONE = 16'h3C00;

  typedef logic [FP16_W-1:0] fp16_t;

  // MSB index of lane k in a bus of `lanes` words; lane 0 is the top slice.
  function automatic int unsigned lane_msb(input int unsigned lanes, input int unsigned k);
    return FP16_W * (lanes - k) - 1;
  endfunction

endpackage

// File: rtl/operand_packer_if.sv
// Operand stream in / packed beat out, as seen by the packer (slave) and by
// whoever drives and consumes it (master).
interface operand_packer_if #(
  parameter int unsigned n = 4
);
  import fp16_pkg::*;

  fp16_t               idata;
  logic                ivalid;
  logic                iready;
  logic                istart;
  logic                ilast;
  logic [FP16_W*n-1:0] odata;
  logic [n-1:0]        oselect;
  logic                ovalid;
  logic                oready;
  logic                ostart;
  logic                olast;
  logic                oerr;

  modport slave (
    input  idata, ivalid, istart, ilast, oready,
    output iready, odata, oselect, ovalid, ostart, olast, oerr
  );

  modport master (
    output idata, ivalid, istart, ilast, oready,
    input  iready, odata, oselect, ovalid, ostart, olast, oerr
  );

endinterface

// File: rtl/operand_out_reg.sv
// Single-entry valid/ready holding register for one packed beat. The caller
// only asserts i_load when the entry is empty or draining this cycle.
module operand_out_reg
  import fp16_pkg::*;
#(
  parameter int unsigned n   = 4,
  parameter fp16_t       PAD = FP16_ONE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [FP16_W*n-1:0] i_data,
  input  logic [n-1:0]        i_select,
  input  logic                i_start,
  input  logic                i_last,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [FP16_W*n-1:0] o_data,
  output logic [n-1:0]        o_select,
  output logic                o_start,
  output logic                o_last
);

  logic                r_valid;
  logic [FP16_W*n-1:0] r_data;
  logic [n-1:0]        r_select;
  logic                r_start;
  logic                r_last;

  // Load a new beat, or drop valid once the current one is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= {n{PAD}};
      r_select <= '0;
      r_start  <= 1'b0;
      r_last   <= 1'b0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_data   <= i_data;
      r_select <= i_select;
      r_start  <= i_start;
      r_last   <= i_last;
    end else if (r_valid && i_ready) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_select = r_select;
  assign o_start  = r_start;
  assign o_last   = r_last;

endmodule

// File: rtl/operand_packer.sv
// Serial-to-parallel FP16 packer: gathers up to n words of a framed stream into
// one beat for the multiplier tree, padding unused lanes with the identity.
module operand_packer
  import fp16_pkg::*;
#(
  parameter int unsigned n   = 4,
  parameter fp16_t       PAD = FP16_ONE
) (
  input  logic             aclk,
  input  logic             areset,
  operand_packer_if.slave  bus
);

  localparam int unsigned CW = $clog2(n);
  localparam int unsigned FW = $clog2(n + 1);
  localparam int unsigned DW = FP16_W * n;

  // Collect buffer; while r_pend is set it holds a complete group waiting
  // for the output register.
  fp16_t           r_lane [n];
  logic [CW-1:0]   r_count;
  logic            r_sop;
  logic            r_pend;
  logic            r_pend_last;
  logic [FW-1:0]   r_pend_fill;
  logic            r_oerr;

  logic            w_accept;
  logic            w_out_free;
  logic            w_err;
  logic            w_complete;
  logic            w_load;
  logic            w_sop;
  logic [CW-1:0]   w_base;
  logic [FW-1:0]   w_fill;
  fp16_t           w_lanes    [n];
  fp16_t           w_src_lane [n];
  logic [FW-1:0]   w_src_fill;
  logic            w_src_sop;
  logic            w_src_last;
  logic [DW-1:0]   w_beat_data;
  logic [n-1:0]    w_beat_sel;

  assign bus.iready = !r_pend && !areset;
  assign bus.oerr   = r_oerr;

  assign w_accept   = bus.ivalid && bus.iready;
  assign w_out_free = !bus.ovalid || bus.oready;

  // A start word arriving mid-group drops the partial group and restarts at lane 0.
  assign w_err      = w_accept && bus.istart && (r_count != '0);
  assign w_base     = w_err ? '0 : r_count;
  assign w_fill     = FW'(w_base) + FW'(1);
  assign w_sop      = bus.istart || r_sop;
  assign w_complete = w_accept && ((w_base == CW'(n - 1)) || bus.ilast);

  // A held group always has priority; no word is accepted while it waits.
  assign w_load     = r_pend ? w_out_free : (w_complete && w_out_free);

  assign w_src_fill = r_pend ? r_pend_fill : w_fill;
  assign w_src_sop  = r_pend ? r_sop       : w_sop;
  assign w_src_last = r_pend ? r_pend_last : bus.ilast;

  // Per-lane merge of the incoming word and beat formation with identity padding.
  for (genvar k = 0; k < n; k++) begin : g_lane
    assign w_lanes[k]    = (w_base == CW'(k)) ? bus.idata : r_lane[k];
    assign w_src_lane[k] = r_pend ? r_lane[k] : w_lanes[k];
    assign w_beat_data[lane_msb(n, k) -: FP16_W] =
      (FW'(k) < w_src_fill) ? w_src_lane[k] : PAD;
    assign w_beat_sel[n-1-k] = (FW'(k) < w_src_fill);
  end

  // Collect, framing and pending-group bookkeeping.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int unsigned k = 0; k < n; k++) r_lane[k] <= PAD;
      r_count     <= '0;
      r_sop       <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_pend_fill <= '0;
      r_oerr      <= 1'b0;
    end else begin
      r_oerr <= w_err;
      if (r_pend) begin
        if (w_out_free) begin
          r_pend  <= 1'b0;
          r_count <= '0;
          r_sop   <= 1'b0;
        end
      end else if (w_accept) begin
        for (int unsigned k = 0; k < n; k++) r_lane[k] <= w_lanes[k];
        if (w_complete) begin
          r_count <= '0;
          if (w_out_free) begin
            r_sop <= 1'b0;
          end else begin
            r_pend      <= 1'b1;
            r_pend_fill <= w_fill;
            r_pend_last <= bus.ilast;
            r_sop       <= w_sop;
          end
        end else begin
          r_count <= w_base + CW'(1);
          r_sop   <= w_sop;
        end
      end
    end
  end

  operand_out_reg #(
    .n   (n),
    .PAD (PAD)
  ) u_out_reg (
    .clk      (aclk),
    .rst      (areset),
    .i_load   (w_load),
    .i_data   (w_beat_data),
    .i_select (w_beat_sel),
    .i_start  (w_src_sop),
    .i_last   (w_src_last),
    .i_ready  (bus.oready),
    .o_valid  (bus.ovalid),
    .o_data   (bus.odata),
    .o_select (bus.oselect),
    .o_start  (bus.ostart),
    .o_last   (bus.olast)
  );

endmodule

// File: tb/tb_operand_packer.sv
// Directed bench for operand_packer with n=4.
module tb_operand_packer;
  import fp16_pkg::*;

  localparam int unsigned N   = 4;
  localparam fp16_t       PAD = 16'h3C00;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  operand_packer_if #(.n(N)) bus ();

  operand_packer #(.n(N), .PAD(PAD)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle();
    bus.ivalid = 1'b0;
    bus.istart = 1'b0;
    bus.ilast  = 1'b0;
    bus.idata  = '0;
  endtask

  // Present one word and hold it until accepted (bounded).
  task automatic put(input fp16_t d, input logic s, input logic l);
    int waited;
    waited     = 0;
    bus.idata  = d;
    bus.istart = s;
    bus.ilast  = l;
    bus.ivalid = 1'b1;
    while (!bus.iready && waited < 20) begin
      tick();
      waited++;
    end
    n_cmp++;
    if (bus.iready !== 1'b1) begin
      n_bad++;
      $display("FAIL put_ready data=%h iready=%b required=1", d, bus.iready);
    end
    tick();
    idle();
  endtask

  function automatic logic [70:0] beat(input logic v, input logic s, input logic l,
                                       input logic [3:0] sel, input logic [63:0] d);
    return {v, s, l, sel, d};
  endfunction

  function automatic logic [70:0] obs();
    return {bus.ovalid, bus.ostart, bus.olast, bus.oselect, bus.odata};
  endfunction

  task automatic test_reset();
    logic [70:0] exp;
    areset = 1'b1;
    idle();
    bus.oready = 1'b1;
    tick();
    tick();
    exp = beat(1'b0, 1'b0, 1'b0, 4'b0000, {4{PAD}});
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL reset_outputs got=%h required=%h", obs(), exp);
    end
    n_cmp++;
    if (bus.iready !== 1'b0) begin
      n_bad++; $display("FAIL reset_iready got=%b required=0", bus.iready);
    end
    n_cmp++;
    if (bus.oerr !== 1'b0) begin
      n_bad++; $display("FAIL reset_oerr got=%b required=0", bus.oerr);
    end
    areset = 1'b0;
    tick();
    n_cmp++;
    if (bus.iready !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_iready got=%b required=1", bus.iready);
    end
  endtask

  task automatic test_full();
    logic [70:0] exp;
    bus.oready = 1'b1;
    put(16'h3C00, 1'b1, 1'b0);
    put(16'h4000, 1'b0, 1'b0);
    put(16'h4200, 1'b0, 1'b0);
    n_cmp++;
    if (bus.ovalid !== 1'b0) begin
      n_bad++; $display("FAIL full_early_valid got=%b required=0", bus.ovalid);
    end
    put(16'h4400, 1'b0, 1'b1);
    exp = beat(1'b1, 1'b1, 1'b1, 4'b1111, 64'h3C00_4000_4200_4400);
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL full_beat got=%h required=%h", obs(), exp);
    end
    tick();
    n_cmp++;
    if (bus.ovalid !== 1'b0) begin
      n_bad++; $display("FAIL full_drain got=%b required=0", bus.ovalid);
    end
  endtask

  task automatic test_short();
    logic [70:0] exp;
    bus.oready = 1'b1;
    put(16'h4000, 1'b1, 1'b0);
    put(16'h4200, 1'b0, 1'b1);
    exp = beat(1'b1, 1'b1, 1'b1, 4'b1100, 64'h4000_4200_3C00_3C00);
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL short_beat got=%h required=%h", obs(), exp);
    end
    tick();
  endtask

  task automatic test_no_start();
    logic [70:0] exp;
    bus.oready = 1'b1;
    put(16'h4600, 1'b0, 1'b1);
    exp = beat(1'b1, 1'b0, 1'b1, 4'b1000, 64'h4600_3C00_3C00_3C00);
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL nostart_beat got=%h required=%h", obs(), exp);
    end
    n_cmp++;
    if (bus.oerr !== 1'b0) begin
      n_bad++; $display("FAIL nostart_oerr got=%b required=0", bus.oerr);
    end
    tick();
  endtask

  task automatic test_span();
    logic [70:0] exp;
    bus.oready = 1'b1;
    put(16'h4000, 1'b1, 1'b0);
    put(16'h4200, 1'b0, 1'b0);
    put(16'h4400, 1'b0, 1'b0);
    put(16'h4600, 1'b0, 1'b0);
    exp = beat(1'b1, 1'b1, 1'b0, 4'b1111, 64'h4000_4200_4400_4600);
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL span_beat1 got=%h required=%h", obs(), exp);
    end
    put(16'h4800, 1'b0, 1'b0);
    n_cmp++;
    if (bus.ovalid !== 1'b0) begin
      n_bad++; $display("FAIL span_gap got=%b required=0", bus.ovalid);
    end
    put(16'h4A00, 1'b0, 1'b1);
    exp = beat(1'b1, 1'b0, 1'b1, 4'b1100, 64'h4800_4A00_3C00_3C00);
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL span_beat2 got=%h required=%h", obs(), exp);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [70:0] exp1;
    logic [70:0] exp2;
    bus.oready = 1'b0;
    for (int i = 0; i < 8; i++) put(16'(32'h4000 + i), (i == 0), (i == 7));
    exp1 = beat(1'b1, 1'b1, 1'b0, 4'b1111, 64'h4000_4001_4002_4003);
    exp2 = beat(1'b1, 1'b0, 1'b1, 4'b1111, 64'h4004_4005_4006_4007);
    n_cmp++;
    if (bus.iready !== 1'b0) begin
      n_bad++; $display("FAIL bp_pending_iready got=%b required=0", bus.iready);
    end
    n_cmp++;
    if (obs() !== exp1) begin
      n_bad++; $display("FAIL bp_beat1 got=%h required=%h", obs(), exp1);
    end
    tick();
    tick();
    n_cmp++;
    if (obs() !== exp1 || bus.iready !== 1'b0) begin
      n_bad++; $display("FAIL bp_hold got=%h iready=%b required=%h iready=0", obs(), bus.iready, exp1);
    end
    bus.oready = 1'b1;
    tick();
    n_cmp++;
    if (obs() !== exp2) begin
      n_bad++; $display("FAIL bp_beat2 got=%h required=%h", obs(), exp2);
    end
    n_cmp++;
    if (bus.iready !== 1'b1) begin
      n_bad++; $display("FAIL bp_iready_back got=%b required=1", bus.iready);
    end
    tick();
    n_cmp++;
    if (bus.ovalid !== 1'b0) begin
      n_bad++; $display("FAIL bp_drain got=%b required=0", bus.ovalid);
    end
  endtask

  task automatic test_framing();
    logic [70:0] exp;
    bus.oready = 1'b1;
    put(16'h4000, 1'b1, 1'b0);
    put(16'h4200, 1'b0, 1'b0);
    put(16'h4800, 1'b1, 1'b0);
    n_cmp++;
    if (bus.oerr !== 1'b1) begin
      n_bad++; $display("FAIL frame_oerr got=%b required=1", bus.oerr);
    end
    n_cmp++;
    if (bus.ovalid !== 1'b0) begin
      n_bad++; $display("FAIL frame_no_partial got=%b required=0", bus.ovalid);
    end
    put(16'h4A00, 1'b0, 1'b1);
    n_cmp++;
    if (bus.oerr !== 1'b0) begin
      n_bad++; $display("FAIL frame_oerr_pulse got=%b required=0", bus.oerr);
    end
    exp = beat(1'b1, 1'b1, 1'b1, 4'b1100, 64'h4800_4A00_3C00_3C00);
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL frame_beat got=%h required=%h", obs(), exp);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [70:0] exp;
    int seen;
    bus.oready = 1'b0;
    for (int i = 0; i < 7; i++) put(16'(32'h5000 + i), (i == 0), 1'b0);
    n_cmp++;
    if (bus.ovalid !== 1'b1) begin
      n_bad++; $display("FAIL mrst_held got=%b required=1", bus.ovalid);
    end
    areset = 1'b1;
    #1;
    n_cmp++;
    if (bus.iready !== 1'b0) begin
      n_bad++; $display("FAIL mrst_iready_during got=%b required=0", bus.iready);
    end
    tick();
    areset = 1'b0;
    #1;
    exp = beat(1'b0, 1'b0, 1'b0, 4'b0000, {4{PAD}});
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL mrst_outputs got=%h required=%h", obs(), exp);
    end
    n_cmp++;
    if (bus.iready !== 1'b1) begin
      n_bad++; $display("FAIL mrst_iready got=%b required=1", bus.iready);
    end
    bus.oready = 1'b1;
    seen = 0;
    repeat (4) begin
      tick();
      if (bus.ovalid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL mrst_stale_beats got=%0d required=0", seen);
    end
    put(16'h4400, 1'b1, 1'b1);
    exp = beat(1'b1, 1'b1, 1'b1, 4'b1000, 64'h4400_3C00_3C00_3C00);
    n_cmp++;
    if (obs() !== exp) begin
      n_bad++; $display("FAIL mrst_fresh_beat got=%h required=%h", obs(), exp);
    end
    tick();
  endtask

  initial begin
    idle();
    bus.oready = 1'b1;
    test_reset();
    test_full();
    test_short();
    test_no_start();
    test_span();
    test_backpressure();
    test_framing();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
